// File: rtl/mod_add_pipe_pkg.sv
// Shared widths and types for the pipelined modular adder and its reduction helper.
package mod_add_pipe_pkg;
    localparam int BIT_WIDTH = 54;
    localparam int TAG_W     = 8;

    typedef logic [BIT_WIDTH-1:0] word_t;
    typedef logic [BIT_WIDTH:0]   sum_t;
    typedef logic [TAG_W-1:0]     tag_t;
endpackage

// File: rtl/mod_add_pipe_if.sv
// Operand/result handshake bundle for mod_add_pipe; slave is the adder side.
interface mod_add_pipe_if;
    import mod_add_pipe_pkg::*;

    word_t q;
    logic  in_valid;
    logic  in_ready;
    word_t a;
    word_t b;
    tag_t  in_tag;
    logic  out_valid;
    logic  out_ready;
    word_t out;
    tag_t  out_tag;

    modport slave (
        input  q, in_valid, a, b, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag
    );

    modport master (
        output q, in_valid, a, b, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag
    );
endinterface

// File: rtl/mod_add_pipe_reduce_once.sv
// Conditional subtract of q from a (BIT_WIDTH+1)-bit value known to be below 2q.
module mod_reduce_once
    import mod_add_pipe_pkg::*;
(
    input  sum_t  sum_i,
    input  word_t q_i,
    output word_t res_o
);
    logic  borrow;
    sum_t  diff;
    logic  diff_msb_unused;

    // One extra bit on the left turns the subtraction's borrow into sum < q.
    assign {borrow, diff}  = {1'b0, sum_i} - {2'b00, q_i};
    assign diff_msb_unused = diff[BIT_WIDTH];
    assign res_o           = borrow ? sum_i[BIT_WIDTH-1:0] : diff[BIT_WIDTH-1:0];
endmodule

// File: rtl/mod_add_pipe.sv
// Two-stage (a + b) mod q with valid/ready on both sides and a tag carried alongside.
module mod_add_pipe
    import mod_add_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mod_add_pipe_if.slave io
);
    logic  s1_valid_q, s1_valid_d;
    sum_t  s1_sum_q,   s1_sum_d;
    tag_t  s1_tag_q,   s1_tag_d;
    logic  s2_valid_q, s2_valid_d;
    word_t s2_out_q,   s2_out_d;
    tag_t  s2_tag_q,   s2_tag_d;
    logic  adv1, adv2;
    word_t reduced;

    mod_reduce_once u_reduce (
        .sum_i (s1_sum_q),
        .q_i   (io.q),
        .res_o (reduced)
    );

    always_comb begin
        adv2       = !s2_valid_q || io.out_ready;
        adv1       = !s1_valid_q || adv2;
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_out_d   = s2_out_q;
        s2_tag_d   = s2_tag_q;

        if (adv1) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_sum_d = {1'b0, io.a} + {1'b0, io.b};
                s1_tag_d = io.in_tag;
            end
        end

        // S2 only reloads on adv2, so a stalled result stays put until taken.
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_out_d = reduced;
                s2_tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_out_q   <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_out_q   <= s2_out_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign io.in_ready  = adv1;
    assign io.out_valid = s2_valid_q;
    assign io.out       = s2_out_q;
    assign io.out_tag   = s2_tag_q;
endmodule

// File: tb/tb_mod_add_pipe.sv
// Scoreboard bench for mod_add_pipe: driver queues expected results, negedge monitor checks them.
module tb_mod_add_pipe;
    import mod_add_pipe_pkg::*;

    localparam word_t Q    = 54'h3F_FFFF_FFFE_D001;
    localparam word_t QM1  = 54'h3F_FFFF_FFFE_D000;
    localparam word_t QM2  = 54'h3F_FFFF_FFFE_CFFF;
    localparam word_t HALF = 54'h20_0000_0000_0000;

    typedef struct packed {
        tag_t  tag;
        word_t val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod_add_pipe_if bus ();

    mod_add_pipe dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    logic fixed_ready = 1'b1;
    logic rand_ready  = 1'b0;
    logic rnd_bit     = 1'b0;
    assign bus.out_ready = rand_ready ? rnd_bit : fixed_ready;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    int   checks    = 0;
    int   passed    = 0;
    int   occ       = 0;
    int   delivered = 0;
    logic verbose   = 1'b1;
    exp_t sb[$];

    logic  hold_prev = 1'b0;
    word_t held_val;
    tag_t  held_tag;
    exp_t  mon_e;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: occupancy model drives the in_ready expectation; results pop from the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            occ       = 0;
            hold_prev = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready == ((occ < 2) || bus.out_ready),
                64'(bus.in_ready), 64'((occ < 2) || bus.out_ready));
            if (hold_prev)
                chk("hold_stable", bus.out_valid && bus.out == held_val && bus.out_tag == held_tag,
                    {2'b0, bus.out_tag, bus.out}, {2'b0, held_tag, held_val});
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 1'b0, {2'b0, bus.out_tag, bus.out}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", bus.out == mon_e.val && bus.out_tag == mon_e.tag,
                        {2'b0, bus.out_tag, bus.out}, {2'b0, mon_e.tag, mon_e.val});
                    if (verbose)
                        $display("out tag=%02h val=%h (expect tag=%02h val=%h)",
                                 bus.out_tag, bus.out, mon_e.tag, mon_e.val);
                end
                delivered++;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held_val  = bus.out;
            held_tag  = bus.out_tag;
            occ = occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
        end
    end

    task automatic send(input word_t a, input word_t b, input tag_t tag, input word_t exp_val);
        logic got;
        got = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            if (got) begin
                sb.push_back('{tag: tag, val: exp_val});
                if (verbose) $display("in  tag=%02h a=%h b=%h", tag, a, b);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!got) chk("accept_timeout", 1'b0, 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", sb.size() == 0, 64'(sb.size()), 64'd0);
    endtask

    function automatic word_t rnd_red();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return word_t'(r % 64'(Q));
    endfunction

    function automatic word_t model(input word_t a, input word_t b);
        logic [55:0] s;
        s = 56'(a) + 56'(b);
        return word_t'(s % 56'(Q));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t ra, rb;
        int    d0;
        bus.q        = Q;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.in_tag   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
        chk("rst_out", bus.out == '0, 64'(bus.out), 64'd0);
        chk("rst_out_tag", bus.out_tag == '0, 64'(bus.out_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency and basic values
        send(54'd0, 54'd0, 8'h01, 54'd0);
        chk("lat_cycle1", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", bus.out_valid == 1'b1 && bus.out == '0, {9'b0, bus.out_valid, bus.out}, {9'b0, 1'b1, 54'd0});
        send(QM1, 54'd1, 8'h02, 54'd0);
        send(54'd2, QM1, 8'h03, 54'd1);
        send(QM1, QM1, 8'h04, QM2);
        send(54'd0, QM1, 8'h05, QM1);
        send(HALF, 54'h1F_FFFF_FFFE_D000, 8'h06, QM1);
        send(HALF, HALF, 8'h07, 54'h1_2FFF);
        drain();

        // Back-to-back stream
        verbose = 1'b0;
        d0 = delivered;
        for (int i = 0; i < 4096; i++) begin
            ra = rnd_red();
            rb = rnd_red();
            send(ra, rb, tag_t'(i), model(ra, rb));
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("throughput", delivered - d0 == 4096, 64'(delivered - d0), 64'd4096);
        drain();

        // Backpressure
        verbose = 1'b1;
        fixed_ready = 1'b0;
        send(54'd10, 54'd20, 8'hA0, 54'd30);
        send(54'd100, 54'd200, 8'hA1, 54'd300);
        chk("bp_in_ready", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'd0);
        fork
            send(QM1, QM1, 8'hA2, QM2);
            begin
                repeat (5) @(posedge clk);
                #1;
                fixed_ready = 1'b1;
            end
        join
        drain();

        // Random valid/ready toggling
        verbose    = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            ra = rnd_red();
            rb = rnd_red();
            send(ra, rb, tag_t'(i + 3), model(ra, rb));
        end
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        drain();

        // Reset with both stages full
        verbose     = 1'b1;
        fixed_ready = 1'b0;
        send(54'd1, 54'd2, 8'hB0, 54'd3);
        send(54'd3, 54'd4, 8'hB1, 54'd7);
        chk("pre_rst_full", bus.out_valid && !bus.in_ready, {62'b0, bus.out_valid, bus.in_ready}, 64'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst         = 1'b0;
        fixed_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(54'd5, 54'd7, 8'h66, 54'd12);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
